// File: rtl/filter_frame_pkg.sv
// Shared types and constants for the filter frame sequencer.
package filter_frame_pkg;

  // Zero samples injected on each side of a frame, and the warm-up outputs discarded
  localparam int PAD  = 3;
  localparam int DROP = 2 * PAD;

  typedef enum logic [1:0] {
    PRE,
    BODY,
    POST
  } state_t;

  // Describes the sample currently held at the filter output
  typedef struct packed {
    logic drop;
    logic last;
  } tag_t;

  // Width of a counter that must reach 2*half_taps
  function automatic int cnt_width(input int half_taps);
    return $clog2(2 * half_taps + 1);
  endfunction

endpackage

// File: rtl/frame_pos_counter.sv
// Saturating up-counter with synchronous clear, used for frame position and pad counts.
module frame_pos_counter
  import filter_frame_pkg::*;
#(
  parameter int width_p = cnt_width(PAD),
  parameter int max_p   = DROP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               inc,
  output logic [width_p-1:0] count
);

  localparam logic [width_p-1:0] MAX = width_p'(max_p);

  // Clear has priority; increments stop once the ceiling is reached
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/filter_frame_ctrl.sv
// Frame sequencer around a 7-tap symmetric FIR: zero-pads each frame edge,
// drops warm-up outputs and flags the final kept output.
module filter_frame_ctrl
  import filter_frame_pkg::*;
#(
  parameter int width_p     = 24,
  parameter int half_taps_p = PAD
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               valid_i,
  input  logic               last_i,
  output logic               ready_o,
  output logic [width_p-1:0] filt_data_o,
  output logic               filt_valid_o,
  input  logic               filt_ready_i,
  input  logic [width_p-1:0] filt_data_i,
  input  logic               filt_valid_i,
  output logic               filt_ready_o,
  output logic [width_p-1:0] data_o,
  output logic               valid_o,
  output logic               last_o,
  input  logic               ready_i
);

  localparam int CNT_W = cnt_width(half_taps_p);
  localparam logic [CNT_W-1:0] PAD_LAST = CNT_W'(half_taps_p - 1);
  localparam logic [CNT_W-1:0] DROP_CNT = CNT_W'(2 * half_taps_p);

  state_t           state;
  state_t           state_next;
  tag_t             tag;
  logic             fin;
  logic             pad_done;
  logic             state_change;
  logic             pos_clear;
  logic             pad_inc;
  logic [CNT_W-1:0] pad_count;
  logic [CNT_W-1:0] pos;

  assign fin          = filt_valid_o & filt_ready_i;
  assign pad_done     = fin & (pad_count == PAD_LAST);
  assign state_change = (state_next != state);
  assign pos_clear    = (state == POST) & (state_next == PRE);
  assign pad_inc      = fin & (state != BODY);

  // State register; reset lands in PRE so stale filter contents get flushed
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= PRE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and filter-input drive: zeros while padding, pass-through in the body
  always_comb begin
    state_next   = state;
    filt_valid_o = 1'b1;
    filt_data_o  = '0;
    ready_o      = 1'b0;
    case (state)
      PRE: begin
        if (pad_done) state_next = BODY;
      end
      BODY: begin
        filt_valid_o = valid_i;
        filt_data_o  = data_i;
        ready_o      = filt_ready_i;
        if (fin && last_i) state_next = POST;
      end
      POST: begin
        if (pad_done) state_next = PRE;
      end
      default: state_next = PRE;
    endcase
  end

  frame_pos_counter #(
    .width_p(CNT_W),
    .max_p  (2 * half_taps_p)
  ) u_pos (
    .clk  (clk_i),
    .rst_n(reset_i),
    .clear(pos_clear),
    .inc  (fin),
    .count(pos)
  );

  frame_pos_counter #(
    .width_p(CNT_W),
    .max_p  (half_taps_p - 1)
  ) u_pad (
    .clk  (clk_i),
    .rst_n(reset_i),
    .clear(state_change),
    .inc  (pad_inc),
    .count(pad_count)
  );

  // Tag follows each filter input, so it always describes the filter's held output
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      tag <= '{drop: 1'b1, last: 1'b0};
    end else if (fin) begin
      tag <= '{drop: (pos < DROP_CNT),
               last: (state == POST) && (pad_count == PAD_LAST)};
    end
  end

  // Output side: sink warm-up samples, otherwise forward with downstream backpressure
  always_comb begin
    filt_ready_o = 1'b1;
    valid_o      = 1'b0;
    last_o       = 1'b0;
    data_o       = filt_data_i;
    if (!tag.drop) begin
      valid_o      = filt_valid_i;
      filt_ready_o = ready_i;
      last_o       = tag.last;
    end
  end

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Self-checking bench for filter_frame_ctrl with a behavioural 7-tap FIR stand-in
// (taps 1,2,4,16,4,2,1 scaled by 1/8) and a queue-based scoreboard.
module tb_filter_frame_ctrl;

  logic        clk_i;
  logic        reset_i;
  logic [23:0] data_i;
  logic        valid_i;
  logic        last_i;
  logic        ready_o;
  logic [23:0] filt_data_o;
  logic        filt_valid_o;
  logic        filt_ready_i;
  logic [23:0] filt_data_i;
  logic        filt_valid_i;
  logic        filt_ready_o;
  logic [23:0] data_o;
  logic        valid_o;
  logic        last_o;
  logic        ready_i;

  typedef struct {
    logic [23:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] frame_q[$];
  int          num_checks = 0;
  int          num_failures = 0;
  int          out_count = 0;
  logic        prev_stalled = 1'b0;

  logic signed [23:0] f_win [0:6];
  logic signed [31:0] f_acc;
  logic               f_valid;
  logic [23:0]        f_data;
  logic               f_ready;

  filter_frame_ctrl #(
    .width_p    (24),
    .half_taps_p(3)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .last_i      (last_i),
    .ready_o     (ready_o),
    .filt_data_o (filt_data_o),
    .filt_valid_o(filt_valid_o),
    .filt_ready_i(filt_ready_i),
    .filt_data_i (filt_data_i),
    .filt_valid_i(filt_valid_i),
    .filt_ready_o(filt_ready_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .last_o      (last_o),
    .ready_i     (ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  assign f_ready      = !f_valid || filt_ready_o;
  assign filt_ready_i = f_ready;
  assign filt_data_i  = f_data;
  assign filt_valid_i = f_valid;

  // Filter stand-in: one output per accepted input, holds one result, sync reset from ~reset_i
  always @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < 7; i++) f_win[i] <= '0;
      f_valid <= 1'b0;
      f_data  <= '0;
    end else if (filt_valid_o && f_ready) begin
      f_acc = $signed(filt_data_o) + 2 * f_win[0] + 4 * f_win[1] + 16 * f_win[2]
              + 4 * f_win[3] + 2 * f_win[4] + f_win[5];
      for (int i = 6; i > 0; i--) f_win[i] <= f_win[i-1];
      f_win[0] <= filt_data_o;
      f_data   <= f_acc[26:3];
      f_valid  <= 1'b1;
    end else if (f_valid && filt_ready_o) begin
      f_valid <= 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Centre-aligned, zero-padded convolution of the current frame
  function automatic logic [23:0] ref_out(input int k);
    longint acc;
    int     coef [0:3];
    int     idx;
    coef = '{16, 4, 2, 1};
    acc  = 0;
    for (int d = -3; d <= 3; d++) begin
      idx = k + d;
      if (idx >= 0 && idx < frame_q.size())
        acc += longint'(coef[(d < 0) ? -d : d]) * longint'($signed(frame_q[idx]));
    end
    return 24'(acc >>> 3);
  endfunction

  // Monitor: scoreboard pop on output handshakes, stall-stability check
  always @(negedge clk_i) begin
    if (!reset_i) begin
      prev_stalled = 1'b0;
    end else begin
      if (prev_stalled) begin
        checkOutput("stall_valid", 32'(valid_o), 32'd1);
        if (exp_q.size() > 0) begin
          checkOutput("stall_data", 32'(data_o), 32'(exp_q[0].data));
          checkOutput("stall_last", 32'(last_o), 32'(exp_q[0].last));
        end
      end
      if (valid_o && ready_i) begin
        exp_t e;
        out_count++;
        if (exp_q.size() == 0) begin
          checkOutput("extra_output", 32'(data_o), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_data", 32'(data_o), 32'(e.data));
          checkOutput("out_last", 32'(last_o), 32'(e.last));
        end
      end
      prev_stalled = valid_o && !ready_i;
    end
  end

  // Drive one sample and hold it until accepted (called at posedge+1)
  task automatic applyStimulus(input logic [23:0] data, input logic last);
    int waited;
    data_i  = data;
    last_i  = last;
    valid_i = 1'b1;
    waited  = 0;
    forever begin
      @(negedge clk_i);
      if (ready_o) break;
      waited++;
      if (waited > 200) begin
        checkOutput("ready_timeout", 32'(ready_o), 32'd1);
        break;
      end
    end
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  // Push the frame's expected outputs, then drive it with an optional valid gap
  task automatic applyFrame(input int gap_after, input int gap_len);
    exp_t e;
    for (int k = 0; k < frame_q.size(); k++) begin
      e.data = ref_out(k);
      e.last = (k == frame_q.size() - 1);
      exp_q.push_back(e);
    end
    for (int k = 0; k < frame_q.size(); k++) begin
      applyStimulus(frame_q[k], k == frame_q.size() - 1);
      if (k == gap_after) begin
        repeat (gap_len) @(posedge clk_i);
        #1;
        checkOutput("gap_filt_valid", 32'(filt_valid_o), 32'd0);
        checkOutput("gap_valid_o", 32'(valid_o), 32'd0);
      end
    end
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 1000) begin
      @(posedge clk_i);
      #1;
      waited++;
    end
    if (exp_q.size() != 0) checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (12) @(posedge clk_i);
    #1;
  endtask

  task automatic load_const(input int n, input logic [23:0] v);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(v);
  endtask

  initial begin
    int base;
    int waited;
    reset_i = 1'b0;
    data_i  = '0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_valid_o", 32'(valid_o), 32'd0);
    checkOutput("rst_last_o", 32'(last_o), 32'd0);
    checkOutput("rst_ready_o", 32'(ready_o), 32'd0);
    checkOutput("rst_filt_valid", 32'(filt_valid_o), 32'd1);
    reset_i = 1'b1;

    $display("[TB] single-sample frame");
    load_const(1, 24'h000100);
    applyFrame(-1, 0);
    wait_drain();

    $display("[TB] four-sample frame");
    load_const(4, 24'h000800);
    applyFrame(-1, 0);
    wait_drain();

    $display("[TB] four-sample frame with downstream stall");
    load_const(4, 24'h000800);
    base = out_count;
    fork
      applyFrame(-1, 0);
      begin
        waited = 0;
        while (out_count < base + 2 && waited < 500) begin
          @(posedge clk_i);
          #1;
          waited++;
        end
        ready_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        ready_i = 1'b1;
      end
    join
    wait_drain();

    $display("[TB] back-to-back frames");
    load_const(1, 24'h000100);
    applyFrame(-1, 0);
    load_const(4, 24'h000800);
    applyFrame(-1, 0);
    wait_drain();

    $display("[TB] reset mid-frame");
    applyStimulus(24'h000800, 1'b0);
    applyStimulus(24'h000800, 1'b0);
    valid_i = 1'b1;
    data_i  = 24'h000800;
    #2;
    checkOutput("mid_ready_before", 32'(ready_o), 32'd1);
    reset_i = 1'b0;
    #1;
    checkOutput("mid_rst_valid_o", 32'(valid_o), 32'd0);
    checkOutput("mid_rst_ready_o", 32'(ready_o), 32'd0);
    valid_i = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    load_const(1, 24'h000100);
    applyFrame(-1, 0);
    wait_drain();

    $display("[TB] valid gap inside frame");
    frame_q.delete();
    for (int i = 1; i <= 6; i++) frame_q.push_back(24'(i * 24'h000100));
    applyFrame(4, 10);
    wait_drain();

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    num_failures++;
    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
    $finish;
  end

endmodule
